// File: rtl/rst_sequencer.sv
// Multi-channel active-low reset sequencer: each channel emits 2*PULSES-1 toggles at its own phase length.
// Define RSTSEQ_LO_GEN_EN to also generate a free-running LO square wave on lo_o (otherwise lo_o is tied low).
module rst_sequencer #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16,
  parameter int PULSES   = 2,
  parameter int LO_HALF  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [CHANNELS*CNT_W-1:0] period_i,
  output logic [CHANNELS-1:0]       chan_rst_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      lo_o
);

  localparam int TOGGLES = 2 * PULSES - 1;
  localparam int TOG_W   = $clog2(TOGGLES + 1);
  localparam logic [TOG_W-1:0] LAST_TOG = TOG_W'(TOGGLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    period_q [CHANNELS];
  logic [CNT_W-1:0]    period_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q    [CHANNELS];
  logic [CNT_W-1:0]    cnt_d    [CHANNELS];
  logic [TOG_W-1:0]    tog_q    [CHANNELS];
  logic [TOG_W-1:0]    tog_d    [CHANNELS];
  logic [CHANNELS-1:0] chan_q, chan_d;
  logic [CHANNELS-1:0] fin_q, fin_d;
  logic                start;

  // IDLE always starts on its first edge out of reset; DONE only restarts on request.
  assign start = (state_q == IDLE) || ((state_q == DONE) && start_i);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    tog_d    = tog_q;
    chan_d   = chan_q;
    fin_d    = fin_q;
    if (start) begin
      state_d = RUN;
      for (int k = 0; k < CHANNELS; k++) begin
        period_d[k] = (period_i[k*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                          : period_i[k*CNT_W +: CNT_W];
        cnt_d[k]    = '0;
        tog_d[k]    = '0;
        chan_d[k]   = 1'b0;
        fin_d[k]    = 1'b0;
      end
    end else if (state_q == RUN) begin
      if (&fin_q) begin
        state_d = DONE;
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (!fin_q[k]) begin
          if (cnt_q[k] == period_q[k] - CNT_W'(1)) begin
            chan_d[k] = ~chan_q[k];
            cnt_d[k]  = '0;
            tog_d[k]  = tog_q[k] + TOG_W'(1);
            if (tog_q[k] == LAST_TOG) begin
              fin_d[k] = 1'b1;
            end
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      chan_q  <= '0;
      fin_q   <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        period_q[k] <= '0;
        cnt_q[k]    <= '0;
        tog_q[k]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      fin_q    <= fin_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tog_q    <= tog_d;
    end
  end

  assign chan_rst_o = chan_q;
  assign busy_o     = (state_q == RUN);
  assign done_o     = &fin_q;

`ifdef RSTSEQ_LO_GEN_EN
  localparam int LO_W = $clog2(LO_HALF + 1);

  logic [LO_W-1:0] lo_cnt_q, lo_cnt_d;
  logic            lo_q, lo_d;

  // Counter runs 1..LO_HALF so the first inversion lands LO_HALF edges after the first edge out of reset.
  always_comb begin
    lo_cnt_d = lo_cnt_q + LO_W'(1);
    lo_d     = lo_q;
    if (lo_cnt_q == LO_W'(LO_HALF)) begin
      lo_d     = ~lo_q;
      lo_cnt_d = LO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_cnt_q <= '0;
      lo_q     <= 1'b0;
    end else begin
      lo_cnt_q <= lo_cnt_d;
      lo_q     <= lo_d;
    end
  end

  assign lo_o = lo_q;
`else
  logic lo_half_unused;
  assign lo_half_unused = (LO_HALF > 0);
  assign lo_o           = 1'b0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: a 2-channel/2-pulse instance and a 1-channel/1-pulse instance share clock, reset and start.
// LO expectations follow RSTSEQ_LO_GEN_EN as seen by the bench.
module tb_rst_sequencer;

  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_i;
  logic [2*CNT_W-1:0] period_i;
  logic [1:0]         chan_rst_o;
  logic               busy_o, done_o, lo_o;

  logic [7:0]         period1;
  logic [0:0]         chan1;
  logic               busy1, done1, lo1;

  int checks = 0;
  int errors = 0;
  int edge_idx = -1;

  always #5 clk = ~clk;

  rst_sequencer #(.CHANNELS(2), .CNT_W(CNT_W), .PULSES(2), .LO_HALF(4)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .period_i(period_i),
    .chan_rst_o(chan_rst_o), .busy_o(busy_o), .done_o(done_o), .lo_o(lo_o)
  );

  rst_sequencer #(.CHANNELS(1), .CNT_W(8), .PULSES(1), .LO_HALF(4)) u_single (
    .clk(clk), .rst(rst), .start_i(start_i), .period_i(period1),
    .chan_rst_o(chan1), .busy_o(busy1), .done_o(done1), .lo_o(lo1)
  );

  // Level of a channel n edges after its start edge.
  function automatic logic exp_level(int n, int p, int pulses);
    int t;
    t = n / p;
    if (t > 2 * pulses - 1) t = 2 * pulses - 1;
    return t[0];
  endfunction

  function automatic logic exp_lo(int e);
`ifdef RSTSEQ_LO_GEN_EN
    int t;
    t = e / 4;
    return t[0];
`else
    return (e < 0) ? 1'b0 : 1'b0;
`endif
  endfunction

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_idx++;
  endtask

  task automatic check_edge(int n, int p0, int p1);
    int last;
    last = 3 * ((p0 > p1) ? p0 : p1);
    check_output($sformatf("ch0 S+%0d", n),    32'(chan_rst_o[0]), 32'(exp_level(n, p0, 2)));
    check_output($sformatf("ch1 S+%0d", n),    32'(chan_rst_o[1]), 32'(exp_level(n, p1, 2)));
    check_output($sformatf("done S+%0d", n),   32'(done_o),        32'(n >= last));
    check_output($sformatf("busy S+%0d", n),   32'(busy_o),        32'(n <= last));
    check_output($sformatf("lo e%0d", edge_idx), 32'(lo_o),        32'(exp_lo(edge_idx)));
    check_output($sformatf("single ch S+%0d", n),   32'(chan1[0]), 32'(exp_level(n, 6, 1)));
    check_output($sformatf("single done S+%0d", n), 32'(done1),    32'(n >= 6));
    check_output($sformatf("single busy S+%0d", n), 32'(busy1),    32'(n <= 6));
    check_output($sformatf("single lo e%0d", edge_idx), 32'(lo1),  32'(exp_lo(edge_idx)));
  endtask

  task automatic check_reset_state(string tag);
    check_output({tag, " chan"},        32'(chan_rst_o), 32'(0));
    check_output({tag, " busy"},        32'(busy_o),     32'(0));
    check_output({tag, " done"},        32'(done_o),     32'(0));
    check_output({tag, " lo"},          32'(lo_o),       32'(0));
    check_output({tag, " single chan"}, 32'(chan1),      32'(0));
    check_output({tag, " single busy"}, 32'(busy1),      32'(0));
    check_output({tag, " single done"}, 32'(done1),      32'(0));
  endtask

  // Edge 0 is the start edge; a start pulse (with a new ch0 period) can be injected mid-run.
  task automatic run_sequence(int p0, int p1, int last_n, int pulse_at, int mid_p0);
    for (int n = 0; n <= last_n; n++) begin
      step();
      if (n == 0) start_i = 1'b0;
      check_edge(n, p0, p1);
      if (n == pulse_at) begin
        start_i = 1'b1;
        period_i[CNT_W-1:0] = CNT_W'(mid_p0);
      end
      if (n == pulse_at + 1) start_i = 1'b0;
    end
  endtask

  initial begin
    rst      = 1'b0;
    start_i  = 1'b0;
    period_i = {16'd5, 16'd3};
    period1  = 8'd6;
    #2;
    check_reset_state("reset");

    @(negedge clk);
    rst      = 1'b1;
    edge_idx = -1;
    $display("[TB] sequence {3,5} with ignored start in RUN");
    run_sequence(3, 5, 16, 3, 4);

    $display("[TB] restart from DONE with ch0 period 4");
    start_i = 1'b1;
    run_sequence(4, 5, 16, -1, 0);

    $display("[TB] restart then async reset mid-sequence");
    period_i[CNT_W-1:0] = 16'd3;
    start_i = 1'b1;
    run_sequence(3, 5, 7, -1, 0);
    check_output("pre-reset ch1", 32'(chan_rst_o[1]), 32'(1));
    rst = 1'b0;
    #1;
    check_reset_state("mid reset");
    #3;
    rst      = 1'b1;
    edge_idx = -1;
    run_sequence(3, 5, 16, -1, 0);

    $display("[TB] restart with ch0 period 0");
    period_i[CNT_W-1:0] = 16'd0;
    start_i = 1'b1;
    run_sequence(1, 5, 16, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
